cacheline_adapter: RTL and testbench
====================================

Name: cacheline_adapter

Overview:
- Sits directly downstream of the L1 wide cache datapath, between its 256-bit line port (pmem_address, pmem_rdata, pmem_wdata) and physical memory.
- Physical memory uses a 64-bit burst interface.
- Converts one cache line fill or writeback into a 4-beat burst.
- Presents the cache with a single-request, single-response handshake.

Parameters:
- LINE_W, 256, cache line width in bits; must be a multiple of BURST_W.
- BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W (4 by default); OFFS = log2(LINE_W/8) (5 by default).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- line_address_i  in  32  line address from the cache.
- line_read_i  in  1  fill request; held until line_resp_o.
- line_write_i  in  1  writeback request; held until line_resp_o.
- line_wdata_i  in  LINE_W  line to write back.
- line_rdata_o  out  LINE_W  assembled fill line.
- line_resp_o  out  1  one-cycle completion pulse.
- mem_address_o  out  32  line-aligned burst address.
- mem_read_o  out  1  burst read request.
- mem_write_o  out  1  burst write request.
- mem_wdata_o  out  BURST_W  current write beat.
- mem_rdata_i  in  BURST_W  current read beat.
- mem_resp_i  in  1  beat accepted or returned this cycle.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE, beat counter=0, line_resp_o=0, mem_read_o=0, mem_write_o=0.
  - mem_address_o=0, mem_wdata_o=0, line_rdata_o=0.
  - An in-flight burst is abandoned; the memory model is reset alongside.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - line_write_i=1 -> WRITE. Write has priority if both requests are high.
  - else line_read_i=1 -> READ.
  - On entry to either: latch mem_address_o={line_address_i[31:OFFS], OFFS'b0}, latch line_wdata_i into the write buffer, clear the counter.
  - mem_resp_i in IDLE is ignored.
- READ:
  - mem_read_o=1 for the whole state.
  - Each cycle with mem_resp_i=1: line_rdata_o[k*BURST_W +: BURST_W] <= mem_rdata_i, where k = counter, then counter++.
  - Beats need not be consecutive; cycles without mem_resp_i are wait cycles with no change.
  - On the beat where counter==BEATS-1 -> DONE.
- WRITE:
  - mem_write_o=1; mem_wdata_o = buffer[k*BURST_W +: BURST_W] combinationally from the counter.
  - Each mem_resp_i advances the counter; last beat -> DONE.
  - Changes to line_wdata_i after acceptance have no effect.
- DONE:
  - line_resp_o=1 for exactly one cycle; mem_read_o=mem_write_o=0; unconditionally -> IDLE.
  - Requests are not sampled in DONE; the cache drops its request the cycle after line_resp_o.
- Latency:
  - line_resp_o is asserted the cycle after the final mem_resp_i.
  - Minimum request-to-response is 1 (accept) + BEATS + 1 cycles = 6 with back-to-back beats.
- line_rdata_o stays stable from line_resp_o until the next READ's first beat. WRITE does not modify line_rdata_o.
- mem_address_o is held constant throughout a burst. Address bits [OFFS-1:0] are always 0.
- Counter width is log2(BEATS). It wraps to 0 after the last beat; no overflow state.

Optional Feature:
- Macro: CACHELINE_ADAPTER_PERF_EN.
- With the macro defined, three extra outputs are added:
  - perf_fills_o [31:0]: completed fill bursts.
  - perf_wbs_o [31:0]: completed writeback bursts.
  - perf_wait_o [31:0]: cycles in READ/WRITE with mem_resp_i=0.
- Counter rules:
  - Fill and writeback counts increment in DONE according to the burst type.
  - All three saturate at 32'hFFFFFFFF.
  - All three clear on reset.
- Without the macro: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Fill, no stalls:
  - Stimulus: line_read_i=1, line_address_i=32'h0000_1234; beats 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444... on consecutive cycles.
  - Required: mem_address_o=32'h0000_1220; line_resp_o one cycle after the 4th beat; line_rdata_o={4444..,3333..,2222..,1111..}; total 6 cycles.
- Writeback with stalls:
  - Stimulus: line_write_i=1, line_wdata_i=256'h(D3,C2,B1,A0 per 64-bit lane); mem_resp_i gaps of 0,2,0,3 cycles; line_wdata_i changed after accept.
  - Required: mem_wdata_o sequence A0,B1,C2,D3, each held until its resp; line_resp_o single pulse.
- Simultaneous line_read_i=1 and line_write_i=1 in IDLE -> WRITE burst first (mem_write_o=1, mem_read_o=0).
- Reset mid-burst:
  - Stimulus: rst=0 after 2 read beats.
  - Required: mem_read_o=0 and line_resp_o=0 immediately, without waiting for clk; next fill starts at beat 0 with the correct assembled line.
- Back-to-back requests:
  - Stimulus: writeback then fill to the same index, request re-asserted the cycle after line_resp_o.
  - Required: each burst gets exactly one line_resp_o; no spurious response; mem_resp_i in IDLE ignored.
- With CACHELINE_ADAPTER_PERF_EN, after the first two scenarios -> perf_fills_o=1, perf_wbs_o=1, perf_wait_o=5.

Source files
------------

// File: rtl/cacheline_adapter.sv
// Adapts a single-request LINE_W-bit cache line port to a BEATS-beat BURST_W-bit memory burst.
// Optional performance counters are built when CACHELINE_ADAPTER_PERF_EN is defined.
module cacheline_adapter #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        line_address_i,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [LINE_W-1:0]  line_wdata_i,
  output logic [LINE_W-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic [31:0]        mem_address_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [BURST_W-1:0] mem_wdata_o,
  input  logic [BURST_W-1:0] mem_rdata_i,
  input  logic               mem_resp_i
`ifdef CACHELINE_ADAPTER_PERF_EN
  ,
  output logic [31:0]        perf_fills_o,
  output logic [31:0]        perf_wbs_o,
  output logic [31:0]        perf_wait_o
`endif
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt;
  logic [LINE_W-1:0] wbuf;
  logic [31:0]       base;
  logic              accept, beat, last;

  assign last = (cnt == CW'(BEATS - 1));
  assign base = 32'(cnt) * BURST_W;

  // Write beat is selected straight from the latched line by the beat counter.
  assign mem_wdata_o = (state == WRITE) ? wbuf[base +: BURST_W] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    beat    = 1'b0;
    case (state)
      IDLE: begin
        if (line_write_i) begin
          state_d = WRITE;
          accept  = 1'b1;
        end else if (line_read_i) begin
          state_d = READ;
          accept  = 1'b1;
        end
      end
      READ, WRITE: begin
        if (mem_resp_i) begin
          beat = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      line_resp_o   <= 1'b0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_address_o <= '0;
      wbuf          <= '0;
      line_rdata_o  <= '0;
    end else begin
      line_resp_o <= (state_d == DONE);
      mem_read_o  <= (state_d == READ);
      mem_write_o <= (state_d == WRITE);
      if (accept) begin
        mem_address_o <= line_address_i & ADDR_MASK;
        wbuf          <= line_wdata_i;
        cnt           <= '0;
      end else if (beat) begin
        cnt <= last ? '0 : cnt + CW'(1);
        if (state == READ) line_rdata_o[base +: BURST_W] <= mem_rdata_i;
      end
    end
  end

`ifdef CACHELINE_ADAPTER_PERF_EN
  logic is_wb;

  // Saturating burst and stall counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wb        <= 1'b0;
      perf_fills_o <= '0;
      perf_wbs_o   <= '0;
      perf_wait_o  <= '0;
    end else begin
      if (accept) is_wb <= (state_d == WRITE);
      if (state == DONE && !is_wb && perf_fills_o != '1) perf_fills_o <= perf_fills_o + 32'd1;
      if (state == DONE && is_wb && perf_wbs_o != '1)    perf_wbs_o   <= perf_wbs_o + 32'd1;
      if ((state == READ || state == WRITE) && !mem_resp_i && perf_wait_o != '1)
        perf_wait_o <= perf_wait_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed scenarios plus randomized bursts.
// Perf counter checks are compiled in when CACHELINE_ADAPTER_PERF_EN is defined.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_address_i;
  logic         line_read_i, line_write_i;
  logic [255:0] line_wdata_i, line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  mem_address_o;
  logic         mem_read_o, mem_write_o;
  logic [63:0]  mem_wdata_o, mem_rdata_i;
  logic         mem_resp_i;
`ifdef CACHELINE_ADAPTER_PERF_EN
  logic [31:0]  perf_fills_o, perf_wbs_o, perf_wait_o;
`endif

  cacheline_adapter dut (
`ifdef CACHELINE_ADAPTER_PERF_EN
    .perf_fills_o(perf_fills_o), .perf_wbs_o(perf_wbs_o), .perf_wait_o(perf_wait_o),
`endif
    .clk(clk), .rst(rst),
    .line_address_i(line_address_i), .line_read_i(line_read_i), .line_write_i(line_write_i),
    .line_wdata_i(line_wdata_i), .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
    .mem_address_o(mem_address_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Observations gathered by the burst driver; expectations live in the test tasks.
  int             cyc, resp_cnt, resp_at;
  logic           obs_rd, obs_wr, rw_bad, wd_bad, done_rw, idle_rw;
  logic [31:0]    obs_addr;
  logic [3:0][63:0] obs_wb;
  logic [255:0]   exp_line;

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic int gsum(input logic [3:0][1:0] g);
    return int'(g[0]) + int'(g[1]) + int'(g[2]) + int'(g[3]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (line_resp_o) begin
      resp_cnt++;
      if (resp_at < 0) resp_at = cyc;
    end
  endtask

  // Plays the cache and the memory for one complete request; gaps[k] idle cycles precede beat k.
  task automatic burst(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [255:0] wdata, input logic [3:0][63:0] beats,
                       input logic [3:0][1:0] gaps, input logic poke);
    cyc = 0; resp_cnt = 0; resp_at = -1; rw_bad = 1'b0; wd_bad = 1'b0;
    line_write_i = wr; line_read_i = rd; line_address_i = addr; line_wdata_i = wdata;
    tick();
    obs_rd = mem_read_o; obs_wr = mem_write_o; obs_addr = mem_address_o;
    line_wdata_i = rnd_line();
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g <= int'(gaps[k]); g++) begin
        if (g == 0) obs_wb[k] = mem_wdata_o;
        else if (mem_wdata_o !== obs_wb[k]) wd_bad = 1'b1;
        if (mem_read_o !== obs_rd || mem_write_o !== obs_wr || mem_address_o !== obs_addr) rw_bad = 1'b1;
        mem_resp_i  = (g == int'(gaps[k]));
        mem_rdata_i = (g == int'(gaps[k])) ? beats[k] : rnd64();
        tick();
      end
    end
    mem_resp_i = 1'b0; mem_rdata_i = rnd64();
    done_rw = mem_read_o | mem_write_o;
    tick();
    line_read_i = 1'b0; line_write_i = 1'b0;
    mem_resp_i = poke; mem_rdata_i = rnd64();
    tick();
    mem_resp_i = 1'b0;
    idle_rw = mem_read_o | mem_write_o | line_resp_o;
  endtask

  task automatic test_reset();
    rst = 1'b0; line_address_i = '0; line_read_i = 1'b0; line_write_i = 1'b0;
    line_wdata_i = '0; mem_rdata_i = '0; mem_resp_i = 1'b0;
    #12;
    vectors++;
    if ({line_resp_o, mem_read_o, mem_write_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000", {line_resp_o, mem_read_o, mem_write_o});
    end
    vectors++;
    if (mem_address_o !== 32'h0 || mem_wdata_o !== 64'h0) begin
      errors++; $display("FAIL reset_mem: addr %h wdata %h want 0", mem_address_o, mem_wdata_o);
    end
    vectors++;
    if (line_rdata_o !== 256'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", line_rdata_o);
    end
`ifdef CACHELINE_ADAPTER_PERF_EN
    vectors++;
    if ({perf_fills_o, perf_wbs_o, perf_wait_o} !== 96'h0) begin
      errors++; $display("FAIL reset_perf: got %0d %0d %0d want 0", perf_fills_o, perf_wbs_o, perf_wait_o);
    end
`endif
    @(posedge clk); #1; rst = 1'b1;
    exp_line = '0;
  endtask

  task automatic test_fill();
    logic [3:0][63:0] b;
    b = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    burst(1'b0, 1'b1, 32'h0000_1234, rnd_line(), b, '0, 1'b1);
    exp_line = b;
    vectors++;
    if (obs_addr !== 32'h0000_1220) begin
      errors++; $display("FAIL fill_addr: got %h want 00001220", obs_addr);
    end
    vectors++;
    if ({obs_rd, obs_wr, rw_bad, done_rw, idle_rw} !== 5'b10000) begin
      errors++; $display("FAIL fill_ctrl: rd/wr/unstable/done/idle got %b want 10000",
                         {obs_rd, obs_wr, rw_bad, done_rw, idle_rw});
    end
    vectors++;
    if (resp_cnt !== 1 || resp_at + 1 !== 6) begin
      errors++; $display("FAIL fill_resp: count %0d latency %0d want 1 and 6", resp_cnt, resp_at + 1);
    end
    vectors++;
    if (line_rdata_o !== exp_line) begin
      errors++; $display("FAIL fill_data: got %h want %h", line_rdata_o, exp_line);
    end
  endtask

  task automatic test_writeback();
    logic [255:0] w;
    logic [3:0][1:0] g;
    w = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
         64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
    g = {2'd3, 2'd0, 2'd2, 2'd0};
    burst(1'b1, 1'b0, 32'h0000_1234, w, {rnd64(), rnd64(), rnd64(), rnd64()}, g, 1'b0);
    vectors++;
    if (obs_wb !== w || wd_bad !== 1'b0) begin
      errors++; $display("FAIL wb_beats: got %h unstable %b want %h", obs_wb, wd_bad, w);
    end
    vectors++;
    if ({obs_rd, obs_wr, rw_bad, done_rw, idle_rw} !== 5'b01000) begin
      errors++; $display("FAIL wb_ctrl: got %b want 01000", {obs_rd, obs_wr, rw_bad, done_rw, idle_rw});
    end
    vectors++;
    if (resp_cnt !== 1 || resp_at + 1 !== 11) begin
      errors++; $display("FAIL wb_resp: count %0d latency %0d want 1 and 11", resp_cnt, resp_at + 1);
    end
    vectors++;
    if (line_rdata_o !== exp_line) begin
      errors++; $display("FAIL wb_rdata_kept: got %h want %h", line_rdata_o, exp_line);
    end
`ifdef CACHELINE_ADAPTER_PERF_EN
    vectors++;
    if (perf_fills_o !== 32'd1 || perf_wbs_o !== 32'd1 || perf_wait_o !== 32'd5) begin
      errors++; $display("FAIL perf: got %0d %0d %0d want 1 1 5", perf_fills_o, perf_wbs_o, perf_wait_o);
    end
`endif
  endtask

  task automatic test_priority();
    logic [255:0] w;
    w = rnd_line();
    burst(1'b1, 1'b1, $urandom(), w, {rnd64(), rnd64(), rnd64(), rnd64()}, 8'($urandom()), 1'b0);
    vectors++;
    if ({obs_rd, obs_wr} !== 2'b01 || obs_wb !== w) begin
      errors++; $display("FAIL priority: rd/wr got %b want 01, beats %h want %h", {obs_rd, obs_wr}, obs_wb, w);
    end
    vectors++;
    if (line_rdata_o !== exp_line || resp_cnt !== 1) begin
      errors++; $display("FAIL priority_side: rdata %h want %h, resp %0d want 1", line_rdata_o, exp_line, resp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0][63:0] b;
    line_read_i = 1'b1; line_address_i = $urandom();
    tick();
    mem_resp_i = 1'b1;
    mem_rdata_i = rnd64(); tick();
    mem_rdata_i = rnd64(); tick();
    mem_resp_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({mem_read_o, line_resp_o} !== 2'b00 || line_rdata_o !== 256'h0) begin
      errors++; $display("FAIL mid_reset: rd/resp got %b want 00, rdata %h want 0", {mem_read_o, line_resp_o}, line_rdata_o);
    end
    line_read_i = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    tick();
    b = {rnd64(), rnd64(), rnd64(), rnd64()};
    burst(1'b0, 1'b1, $urandom(), rnd_line(), b, '0, 1'b0);
    exp_line = b;
    vectors++;
    if (line_rdata_o !== exp_line || resp_cnt !== 1 || resp_at + 1 !== 6) begin
      errors++; $display("FAIL mid_refill: rdata %h want %h, resp %0d lat %0d want 1 6",
                         line_rdata_o, exp_line, resp_cnt, resp_at + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [255:0] w;
    logic [3:0][63:0] b;
    a = $urandom(); w = rnd_line(); b = {rnd64(), rnd64(), rnd64(), rnd64()};
    burst(1'b1, 1'b0, a, w, {rnd64(), rnd64(), rnd64(), rnd64()}, '0, 1'b1);
    vectors++;
    if (obs_wb !== w || resp_cnt !== 1 || idle_rw !== 1'b0 || obs_addr !== (a & 32'hFFFF_FFE0)) begin
      errors++; $display("FAIL b2b_wb: beats %h resp %0d idle %b addr %h want %h 1 0 %h",
                         obs_wb, resp_cnt, idle_rw, obs_addr, w, a & 32'hFFFF_FFE0);
    end
    burst(1'b0, 1'b1, a, rnd_line(), b, '0, 1'b1);
    exp_line = b;
    vectors++;
    if (line_rdata_o !== exp_line || resp_cnt !== 1 || idle_rw !== 1'b0 || obs_addr !== (a & 32'hFFFF_FFE0)) begin
      errors++; $display("FAIL b2b_fill: rdata %h resp %0d idle %b addr %h want %h 1 0 %h",
                         line_rdata_o, resp_cnt, idle_rw, obs_addr, exp_line, a & 32'hFFFF_FFE0);
    end
  endtask

  task automatic test_random();
    logic wr, rd;
    logic [31:0] a;
    logic [255:0] w;
    logic [3:0][63:0] b;
    logic [3:0][1:0] g;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a = $urandom(); w = rnd_line(); b = {rnd64(), rnd64(), rnd64(), rnd64()};
      g = 8'($urandom());
      burst(wr, rd, a, w, b, g, 1'($urandom_range(0, 1)));
      if (!wr) exp_line = b;
      vectors++;
      if (obs_addr !== {a[31:5], 5'b0} || {obs_rd, obs_wr} !== {~wr, wr} || rw_bad !== 1'b0) begin
        errors++; $display("FAIL rnd_req[%0d]: addr %h rd/wr %b unstable %b want %h %b 0",
                           n, obs_addr, {obs_rd, obs_wr}, rw_bad, {a[31:5], 5'b0}, {~wr, wr});
      end
      vectors++;
      if (resp_cnt !== 1 || resp_at + 1 !== 6 + gsum(g) || idle_rw !== 1'b0 || done_rw !== 1'b0) begin
        errors++; $display("FAIL rnd_resp[%0d]: count %0d lat %0d idle %b done %b want 1 %0d 0 0",
                           n, resp_cnt, resp_at + 1, idle_rw, done_rw, 6 + gsum(g));
      end
      vectors++;
      if (line_rdata_o !== exp_line || (wr && (obs_wb !== w || wd_bad))) begin
        errors++; $display("FAIL rnd_data[%0d]: rdata %h want %h, wbeats %h want %h",
                           n, line_rdata_o, exp_line, obs_wb, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
